// File: rtl/imgproc_pkg.sv
// imgproc_pkg: shared image geometry defaults, counter widths and window FSM encoding
package imgproc_pkg;
  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 720;
  localparam int COL_W = 11;
  localparam int ROW_W = 10;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: col/row position of the pixel being accepted; clr forces it to (0,0)
module raster_counter
  import imgproc_pkg::*;
#(
  parameter int W = IMG_W_DEF,
  parameter int H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             wrap,
  output logic             last
);
  logic [COL_W-1:0] c_q;
  logic [ROW_W-1:0] r_q;
  // Outputs describe the current pixel, so a restart pixel reads as (0,0) in its own cycle
  assign col  = clr ? '0 : c_q;
  assign row  = clr ? '0 : r_q;
  assign wrap = col == COL_W'(W - 1);
  assign last = wrap && row == ROW_W'(H - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      c_q <= '0;
      r_q <= '0;
    end else if (en) begin
      c_q <= wrap ? '0 : col + 1'b1;
      r_q <= last ? '0 : wrap ? row + 1'b1 : row;
    end
endmodule

// File: rtl/window_3x3.sv
// window_3x3: 3x3 sliding window over a raster stream, using two external line memories
module window_3x3
  import imgproc_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sof,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic [PIX_W-1:0]   tap1,
  input  logic [PIX_W-1:0]   tap2,
  output logic               lm_we,
  output logic [9*PIX_W-1:0] win,
  output logic               win_valid,
  output logic [COL_W-1:0]   win_x,
  output logic [ROW_W-1:0]   win_y,
  output logic               frame_done
);
  state_t state;
  logic accept, restart, wrap, last, fire;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] sr [3][3];
  assign lm_we   = in_valid;
  assign accept  = in_valid && (sof || state != S_IDLE);
  assign restart = accept && sof;
  assign fire    = accept && !sof && state == S_ACTIVE;
  raster_counter #(.W(IMG_W), .H(IMG_H)) u_cnt (
    .clk, .reset_n, .en(accept), .clr(restart), .col, .row, .wrap, .last
  );
  // sr[row top..bottom][column oldest..newest] maps straight onto the row-major window
  for (genvar i = 0; i < 9; i++) begin : g_win
    assign win[i*PIX_W +: PIX_W] = sr[i/3][i%3];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= S_IDLE;
      sr         <= '{default: '0};
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= fire && col >= COL_W'(2);
      frame_done <= fire && last;
      if (accept) begin
        sr[0] <= '{sr[0][1], sr[0][2], tap2};
        sr[1] <= '{sr[1][1], sr[1][2], tap1};
        sr[2] <= '{sr[2][1], sr[2][2], pix_in};
        win_x <= col - 1'b1;
        win_y <= row - 1'b1;
        state <= sof ? S_FILL :
                 (state == S_FILL && wrap && row == ROW_W'(1)) ? S_ACTIVE :
                 (state == S_ACTIVE && last) ? S_IDLE : state;
      end
    end
endmodule

// File: tb/tb_window_3x3.sv
// tb_window_3x3: randomized self-checking bench against an image-array window model
module tb_window_3x3;
  localparam int W = 8, H = 6, P = 8, N = W * H, NW = (W - 2) * (H - 2);
  typedef struct packed {logic [9*P-1:0] w; logic [10:0] x; logic [9:0] y;} win_t;
  logic clk = 0, reset_n = 0, sof = 0, in_valid = 0;
  logic [P-1:0] pix_in = '0, tap1 = '0, tap2 = '0;
  logic lm_we, win_valid, frame_done;
  logic [9*P-1:0] win;
  logic [10:0] win_x;
  logic [9:0] win_y;
  int checks = 0, errors = 0, fd_cnt = 0;
  logic [P-1:0] img [H][W];
  win_t got[$], exp_q[$];

  window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk(clk), .reset_n(reset_n), .sof(sof), .in_valid(in_valid), .pix_in(pix_in),
    .tap1(tap1), .tap2(tap2), .lm_we(lm_we), .win(win), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset_n) begin
      if (win_valid) got.push_back({win, win_x, win_y});
      if (frame_done) fd_cnt++;
    end

  task automatic fill_img(input bit ramp);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = ramp ? P'(8 * r + c) : P'($urandom);
  endtask

  // Every in-frame window centred at (c-1, r-1), taken directly from the image
  task automatic build_exp();
    exp_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        win_t e;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) e.w[(i*3+j)*P +: P] = img[r-2+i][c-2+j];
        e.x = 11'(c - 1);
        e.y = 10'(r - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pixel(input bit s, input int idx);
    int r = idx / W, c = idx % W;
    sof = s;
    in_valid = 1;
    pix_in = img[r][c];
    tap1 = r >= 1 ? img[r-1][c] : P'($urandom);
    tap2 = r >= 2 ? img[r-2][c] : P'($urandom);
    @(posedge clk);
    #1;
    sof = 0;
    in_valid = 0;
  endtask

  task automatic send(input int from, input int to, input int gap, input bit s_first);
    for (int k = from; k <= to; k++) begin
      if (gap > 0) idle($urandom_range(gap, 0));
      push_pixel(s_first && k == from, k);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({win, win_valid, win_x, win_y, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got win=%h v=%b x=%0d y=%0d fd=%b required all 0",
               win, win_valid, win_x, win_y, frame_done);
    end
    in_valid = 1;
    #1;
    checks++;
    if (lm_we !== 1'b1) begin
      errors++;
      $display("FAIL lm_we_follows got %b required 1", lm_we);
    end
    in_valid = 0;
    #20 reset_n = 1;
    idle(1);
  endtask

  task automatic test_full_frame();
    int g0 = got.size(), f0 = fd_cnt;
    win_t first;
    fill_img(1);
    build_exp();
    send(0, N - 1, 0, 1);
    idle(2);
    checks++;
    if (got.size() - g0 != NW) begin
      errors++;
      $display("FAIL full_count got %0d required %0d", got.size() - g0, NW);
    end
    first = got.size() > g0 ? got[g0] : '0;
    checks++;
    if (first.x !== 11'd1 || first.y !== 10'd1 || first.w[4*P +: P] !== 8'd9) begin
      errors++;
      $display("FAIL full_first got x=%0d y=%0d centre=%0d required 1 1 9",
               first.x, first.y, first.w[4*P +: P]);
    end
    for (int i = 0; i < NW && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_win[%0d] got %h required %h", i, got[g0+i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL full_frame_done got %0d required 1", fd_cnt - f0);
    end
  endtask

  task automatic test_gaps();
    int g0 = got.size(), f0 = fd_cnt;
    fill_img(0);
    build_exp();
    send(0, N - 1, 3, 1);
    idle(2);
    checks++;
    if (got.size() - g0 != NW) begin
      errors++;
      $display("FAIL gaps_count got %0d required %0d", got.size() - g0, NW);
    end
    for (int i = 0; i < NW && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gaps_win[%0d] got %h required %h", i, got[g0+i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL gaps_frame_done got %0d required 1", fd_cnt - f0);
    end
  endtask

  task automatic test_no_wrap();
    fill_img(0);
    for (int k = 0; k < N; k++) begin
      push_pixel(k == 0, k);
      checks++;
      if (win_valid !== ((k / W) >= 2 && (k % W) >= 2)) begin
        errors++;
        $display("FAIL nowrap_valid r=%0d c=%0d got %b required %b", k / W, k % W,
                 win_valid, (k / W) >= 2 && (k % W) >= 2);
      end
      checks++;
      if (frame_done !== (k == N - 1)) begin
        errors++;
        $display("FAIL nowrap_fd k=%0d got %b required %b", k, frame_done, k == N - 1);
      end
    end
    idle(2);
  endtask

  task automatic test_abort();
    int g0, f0 = fd_cnt;
    fill_img(0);
    send(0, 3 * W + 3, 0, 1);
    idle(1);
    fill_img(0);
    build_exp();
    g0 = got.size();
    send(0, N - 1, 0, 1);
    idle(2);
    checks++;
    if (got.size() - g0 != NW) begin
      errors++;
      $display("FAIL abort_count got %0d required %0d", got.size() - g0, NW);
    end
    for (int i = 0; i < NW && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_win[%0d] got %h required %h", i, got[g0+i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL abort_frame_done got %0d required 1", fd_cnt - f0);
    end
  endtask

  task automatic test_sof_on_last();
    int g0, f0 = fd_cnt;
    fill_img(0);
    build_exp();
    send(0, N - 2, 0, 1);
    push_pixel(1, 0);
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL soflast_outputs got v=%b fd=%b required 0 0", win_valid, frame_done);
    end
    g0 = got.size();
    send(1, N - 1, 0, 0);
    idle(2);
    checks++;
    if (got.size() - g0 != NW) begin
      errors++;
      $display("FAIL soflast_count got %0d required %0d", got.size() - g0, NW);
    end
    for (int i = 0; i < NW && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL soflast_win[%0d] got %h required %h", i, got[g0+i], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL soflast_frame_done got %0d required 1", fd_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    int g0, f0;
    fill_img(0);
    send(0, 3 * W + 4, 0, 1);
    checks++;
    if (win_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got v=%b required 1", win_valid);
    end
    reset_n = 0;
    #1;
    checks++;
    if ({win, win_valid, win_x, win_y, frame_done} !== '0) begin
      errors++;
      $display("FAIL midreset_async got win=%h v=%b x=%0d y=%0d fd=%b required all 0",
               win, win_valid, win_x, win_y, frame_done);
    end
    #1 reset_n = 1;
    g0 = got.size();
    f0 = fd_cnt;
    send(3 * W + 5, N - 1, 0, 0);
    idle(2);
    checks++;
    if (got.size() != g0 || fd_cnt != f0) begin
      errors++;
      $display("FAIL midreset_nosof got %0d windows %0d done required 0 0",
               got.size() - g0, fd_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int g0 = got.size(), f0 = fd_cnt;
    fill_img(0);
    build_exp();
    send(0, N - 1, 0, 1);
    send(0, N - 1, 0, 1);
    idle(2);
    checks++;
    if (got.size() - g0 != 2 * NW) begin
      errors++;
      $display("FAIL b2b_count got %0d required %0d", got.size() - g0, 2 * NW);
    end
    for (int i = 0; i < 2 * NW && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i%NW]) begin
        errors++;
        $display("FAIL b2b_win[%0d] got %h required %h", i, got[g0+i], exp_q[i%NW]);
      end
    end
    checks++;
    if (fd_cnt - f0 != 2) begin
      errors++;
      $display("FAIL b2b_frame_done got %0d required 2", fd_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_no_wrap();
    test_abort();
    test_sof_on_last();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 1280, meaning pixels per line.
REQ-002 SHALL have parameter IMG_H, default 720, meaning lines per frame.
REQ-003 SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sof  input  1  start-of-frame; qualified by in_valid and marks pixel (0,0).
REQ-007 SHALL have port in_valid  input  1  pixel and taps valid this cycle.
REQ-008 SHALL have port pix_in  input  PIX_W  current-row pixel, raster order.
REQ-009 SHALL have port tap1  input  PIX_W  same column, one line above, from the first line memory.
REQ-010 SHALL have port tap2  input  PIX_W  same column, two lines above, from the second line memory.
REQ-011 SHALL have port lm_we  output  1  write enable to the line memories; equals in_valid, combinational.
REQ-012 SHALL have port win  output  9*PIX_W  3x3 window; index 0 = top-left, 8 = bottom-right, row-major.
REQ-013 SHALL have port win_valid  output  1  win holds a complete, in-frame window.
REQ-014 SHALL have port win_x  output  11  column of window centre.
REQ-015 SHALL have port win_y  output  10  row of window centre.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-017 SHALL run state machine IDLE -> FILL -> ACTIVE -> IDLE: IDLE->FILL on sof&in_valid; FILL->ACTIVE when row counter reaches 2; ACTIVE->IDLE after pixel (IMG_W-1, IMG_H-1).
REQ-018 SHALL ignore in_valid pixels in IDLE without sof; lm_we still follows in_valid.
REQ-019 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters advancing only on accepted pixels; col wraps to 0 and increments row at IMG_W-1.
REQ-020 SHALL, on each accepted pixel, shift {tap2,tap1,pix_in} into three 3-deep column shift registers; with in_valid low, all state holds.
REQ-021 SHALL register win, win_valid, win_x and win_y one cycle after the accepting edge (latency 1).
REQ-022 SHALL assert win_valid only in ACTIVE with accepted col >= 2, so no window spans a line wrap.
REQ-023 SHALL output win_x = col-1 and win_y = row-1 of the accepted pixel.
REQ-024 SHALL produce exactly (IMG_W-2)*(IMG_H-2) valid windows per complete frame.
REQ-025 SHALL pulse frame_done one cycle after the last pixel is accepted, coincident with the final win_valid.
REQ-026 SHALL, on sof&in_valid in FILL or ACTIVE, abort the frame: counters restart with that pixel as (0,0), state becomes FILL, and no frame_done is produced.
REQ-027 SHALL treat sof coinciding with the last pixel of a frame as a new frame start: restart wins, and neither frame_done nor that window is emitted.
REQ-028 SHALL deassert win_valid in any cycle with no accepted pixel on the prior edge.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear state to IDLE, counters to 0, shift registers to 0, win to 0, win_valid to 0, win_x to 0, win_y to 0 and frame_done to 0.
REQ-030 SHALL, on reset mid-frame, discard all partial data and require a fresh sof.

Structure
REQ-031 SHALL place the IMG_W/IMG_H defaults, the counter widths and the state encoding constants in a shared package, imgproc_pkg.
REQ-032 SHALL implement the col/row counters as one sub-module, raster_counter, with wrap and terminal-count outputs.

Verification (IMG_W=8, IMG_H=6, PIX_W=8)
REQ-033 SHALL check a full frame with pix_in = 8*row+col, tap1/tap2 from a model: 24 windows, the first with win_x=1 and win_y=1 and a centre value of 9.
REQ-034 SHALL check random in_valid gaps of 0-3 cycles: the window sequence is identical to the gapless run and frame_done is high once.
REQ-035 SHALL check at col=0 and col=1 of every row that win_valid=0, so there are no wrap-spanning windows.
REQ-036 SHALL check sof reasserted at row 3, col 4: no frame_done, and the restarted frame yields 24 windows.
REQ-037 SHALL check reset_n pulsed low mid-ACTIVE: outputs are 0 immediately, and pixels before the next sof yield no win_valid.
REQ-038 SHALL check two back-to-back frames with no idle cycle: 48 windows and two frame_done pulses.
